// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR coefficient controller.
package fir_pkg;

   localparam int unsigned EPOCH_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2
   } fir_ctrl_state_t;

   // Inverse-structure filter latency from x_N to y_N: two register stages per tap.
   function automatic int unsigned fir_default_latency(input int unsigned taps);
      return 2 * taps;
   endfunction

endpackage

// File: rtl/fir_valid_tracker.sv
// In-flight sample valid tracking plus the post-swap flush down-counter.
module fir_valid_tracker
   import fir_pkg::*;
#(
   parameter int unsigned LATENCY = fir_default_latency(4)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start_flush,
   input  logic in_valid,
   output logic flushing,
   output logic flush_last,
   output logic out_valid
);

   localparam int unsigned CW = $clog2(LATENCY + 1);

   logic [CW-1:0]      cnt_q, cnt_d;
   logic [LATENCY-1:0] sr_q, sr_d;

   // Next-state: counter reloads on a swap, otherwise drains to zero; valid shifts in every cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (start_flush) begin
         cnt_d = CW'(LATENCY);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
      sr_d = {sr_q[LATENCY-2:0], in_valid};
   end

   // Counter and shift register storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         sr_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         sr_q  <= sr_d;
      end
   end

   assign flushing   = (cnt_q != '0);
   assign flush_last = (cnt_q == CW'(1));
   assign out_valid  = sr_q[LATENCY-1] & ~flushing;

endmodule

// File: rtl/fir_coef_ctrl.sv
// Coefficient bank controller for the inverse-structure fir_filter.
// Optional build macro: FIR_COEF_READBACK_EN adds rd_addr/rd_data readback of the active bank.
module fir_coef_ctrl
   import fir_pkg::*;
#(
   parameter int unsigned TAPS       = 4,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned LATENCY    = fir_default_latency(TAPS)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       cfg_valid,
   output logic                       cfg_ready,
   input  logic [$clog2(TAPS)-1:0]    cfg_addr,
   input  logic [DATA_WIDTH-1:0]      cfg_data,
   input  logic                       cfg_last,
   output logic                       cfg_err,
   output logic [EPOCH_W-1:0]         cfg_epoch,
   input  logic                       in_valid,
   input  logic [DATA_WIDTH-1:0]      in_data,
   output logic [DATA_WIDTH-1:0]      x_N,
   output logic [TAPS*DATA_WIDTH-1:0] w_N,
   input  logic [DATA_WIDTH-1:0]      y_N,
   output logic                       out_valid,
   output logic [DATA_WIDTH-1:0]      out_data
`ifdef FIR_COEF_READBACK_EN
   ,
   input  logic [$clog2(TAPS)-1:0]    rd_addr,
   output logic [DATA_WIDTH-1:0]      rd_data
`endif
);

   localparam int unsigned AW  = $clog2(TAPS);
   localparam int unsigned AW1 = AW + 1;
   localparam int unsigned DW  = DATA_WIDTH;

   fir_ctrl_state_t          state_q;
   logic                     cfg_ready_q;
   logic [TAPS-1:0][DW-1:0]  shadow_q, shadow_d;
   logic [TAPS-1:0][DW-1:0]  active_q, active_d;
   logic [EPOCH_W-1:0]       epoch_q, epoch_d;
   logic                     err_q, err_d;
   logic                     accept, swap, addr_ok;
   logic                     trk_flushing, trk_flush_last, trk_out_valid;

   assign accept = cfg_valid & cfg_ready_q;
   assign swap   = accept & cfg_last;

   // Address range check only exists when TAPS leaves unused address codes.
   generate
      if (TAPS == (2 ** AW)) begin : g_addr_full
         assign addr_ok = 1'b1;
      end else begin : g_addr_partial
         assign addr_ok = ({1'b0, cfg_addr} < AW1'(TAPS));
      end
   endgenerate

   // Shadow write of the accepted beat; the swap copies the merged shadow so the last beat lands too.
   always_comb begin
      shadow_d = shadow_q;
      if (accept) begin
         for (int i = 0; i < TAPS; i++) begin
            if (cfg_addr == AW'(i)) begin
               shadow_d[i] = cfg_data;
            end
         end
      end
      active_d = swap ? shadow_d : active_q;
      epoch_d  = swap ? (epoch_q + EPOCH_W'(1)) : epoch_q;
      err_d    = err_q | (accept & ~addr_ok);
   end

   // Coefficient banks, swap epoch and sticky error storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
         active_q <= '0;
         epoch_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         epoch_q  <= epoch_d;
         err_q    <= err_d;
      end
   end

   // Write-channel FSM with registered ready; FLUSH ends the cycle after the counter reads 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cfg_ready_q <= 1'b1;
      end else begin
         case (state_q)
            IDLE, LOAD: begin
               if (accept) begin
                  if (cfg_last) begin
                     state_q     <= FLUSH;
                     cfg_ready_q <= 1'b0;
                  end else begin
                     state_q <= LOAD;
                  end
               end
            end
            FLUSH: begin
               // The !flushing term recovers if the counter ever drains without passing 1.
               if (trk_flush_last || !trk_flushing) begin
                  state_q     <= IDLE;
                  cfg_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               cfg_ready_q <= 1'b1;
            end
         endcase
      end
   end

   fir_valid_tracker #(
      .LATENCY (LATENCY)
   ) u_valid_tracker (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_flush (swap),
      .in_valid    (in_valid),
      .flushing    (trk_flushing),
      .flush_last  (trk_flush_last),
      .out_valid   (trk_out_valid)
   );

`ifdef FIR_COEF_READBACK_EN
   logic [DW-1:0] rd_data_q, rd_data_d;

   // Readback mux; unmatched addresses read as zero.
   always_comb begin
      rd_data_d = '0;
      for (int i = 0; i < TAPS; i++) begin
         if (rd_addr == AW'(i)) begin
            rd_data_d = active_q[i];
         end
      end
   end

   // One-cycle registered readback.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;
`endif

   assign cfg_ready = cfg_ready_q;
   assign cfg_err   = err_q;
   assign cfg_epoch = epoch_q;
   assign w_N       = active_q;
   assign x_N       = in_valid ? in_data : '0;
   assign out_data  = y_N;
   assign out_valid = trk_out_valid & (state_q != FLUSH);

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Directed self-checking bench for fir_coef_ctrl (TAPS=4, DATA_WIDTH=16, LATENCY=8).
module tb_fir_coef_ctrl;

   localparam int unsigned TAPS = 4;
   localparam int unsigned DW   = 16;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            cfg_valid, cfg_ready, cfg_last, cfg_err;
   logic [1:0]      cfg_addr;
   logic [DW-1:0]   cfg_data;
   logic [7:0]      cfg_epoch;
   logic            in_valid, out_valid;
   logic [DW-1:0]   in_data, x_N, y_N, out_data;
   logic [TAPS*DW-1:0] w_N;
`ifdef FIR_COEF_READBACK_EN
   logic [1:0]      rd_addr;
   logic [DW-1:0]   rd_data;
`endif

   int passed = 0;
   int total  = 0;

   fir_coef_ctrl #(.TAPS(TAPS), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .cfg_last  (cfg_last),
      .cfg_err   (cfg_err),
      .cfg_epoch (cfg_epoch),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .x_N       (x_N),
      .w_N       (w_N),
      .y_N       (y_N),
      .out_valid (out_valid),
      .out_data  (out_data)
`ifdef FIR_COEF_READBACK_EN
      ,
      .rd_addr   (rd_addr),
      .rd_data   (rd_data)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish, required finish within 2ms");
      $fatal(1);
   end

   typedef struct {
      logic          iv;
      logic [DW-1:0] id;
      logic [DW-1:0] y;
      logic [DW-1:0] exp_x;
      logic [DW-1:0] exp_out;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h required %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Tap 0 occupies the least significant slice of w_N.
   function automatic logic [63:0] pack4(input logic [DW-1:0] t0, t1, t2, t3);
      return {t3, t2, t1, t0};
   endfunction

   task automatic wait_ready();
      int n = 0;
      while (!cfg_ready && n < 20) begin
         tick();
         n++;
      end
      check("wait_ready", 64'(cfg_ready), 64'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      rst_n = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_last = 1'b0;
      in_valid = 1'b0; in_data = '0; y_N = '0;
`ifdef FIR_COEF_READBACK_EN
      rd_addr = '0;
`endif
      vecs[0] = '{1'b1, 16'h1234, 16'h0000, 16'h1234, 16'h0000};
      vecs[1] = '{1'b0, 16'habcd, 16'h5555, 16'h0000, 16'h5555};
      vecs[2] = '{1'b1, 16'hffff, 16'h8000, 16'hffff, 16'h8000};
      vecs[3] = '{1'b0, 16'h0001, 16'hffff, 16'h0000, 16'hffff};
      vecs[4] = '{1'b1, 16'h0000, 16'h7fff, 16'h0000, 16'h7fff};

      // Reset state
      do_reset();
      check("rst_ready", 64'(cfg_ready), 64'd1);
      check("rst_err", 64'(cfg_err), 64'd0);
      check("rst_epoch", 64'(cfg_epoch), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_w_N", w_N, 64'd0);

      // Datapath passthrough and zero-stuffing table
      for (int i = 0; i < 5; i++) begin
         in_valid = vecs[i].iv; in_data = vecs[i].id; y_N = vecs[i].y;
         #1;
         check($sformatf("vec%0d_x_N", i), 64'(x_N), 64'(vecs[i].exp_x));
         check($sformatf("vec%0d_out_data", i), 64'(out_data), 64'(vecs[i].exp_out));
      end
      in_valid = 1'b0; in_data = '0; y_N = '0;
      tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick();

      // Single valid sample emerges exactly LATENCY cycles later
      in_valid = 1'b1; in_data = 16'd1;
      #1;
      check("lat_x_N", 64'(x_N), 64'd1);
      check("lat_c0_out_valid", 64'(out_valid), 64'd0);
      tick();
      in_valid = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         check($sformatf("lat_c%0d_out_valid", i), 64'(out_valid), 64'(i == 8));
         if (i == 8) begin
            check("lat_out_data", 64'(out_data), 64'd0);
            check("lat_epoch", 64'(cfg_epoch), 64'd0);
         end
         tick();
      end

      // Full burst 1,2,3,4 with a continuously valid input stream
      in_valid = 1'b1; in_data = 16'd3;
      for (int i = 0; i < 8; i++) tick();
      for (int b = 0; b < 4; b++) begin
         cfg_valid = 1'b1; cfg_addr = 2'(b); cfg_data = DW'(b + 1); cfg_last = (b == 3);
         #1;
         check($sformatf("burst_b%0d_ready", b), 64'(cfg_ready), 64'd1);
         check($sformatf("burst_b%0d_out_valid", b), 64'(out_valid), 64'd1);
         tick();
      end
      cfg_valid = 1'b0; cfg_last = 1'b0;
      check("burst_w_N", w_N, pack4(16'd1, 16'd2, 16'd3, 16'd4));
      check("burst_epoch", 64'(cfg_epoch), 64'd1);
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("burst_flush_c%0d_ready_ov", i), 64'({cfg_ready, out_valid}), 64'b00);
         tick();
      end
      check("burst_exit_ready_ov", 64'({cfg_ready, out_valid}), 64'b11);
`ifdef FIR_COEF_READBACK_EN
      rd_addr = 2'd1;
      tick();
      check("readback_tap1", 64'(rd_data), 64'd2);
`endif

      // Single-beat commit, then cfg_valid held through FLUSH
      cfg_valid = 1'b1; cfg_addr = 2'd2; cfg_data = 16'd7; cfg_last = 1'b1;
      #1;
      check("single_ready", 64'(cfg_ready), 64'd1);
      tick();
      cfg_addr = 2'd0; cfg_last = 1'b0;
      check("single_w_N", w_N, pack4(16'd1, 16'd2, 16'd7, 16'd4));
      for (int i = 1; i <= 8; i++) begin
         cfg_data = DW'(100 + i);
         #1;
         check($sformatf("hold_flush_c%0d_ready", i), 64'(cfg_ready), 64'd0);
         check($sformatf("hold_flush_c%0d_w_N", i), w_N, pack4(16'd1, 16'd2, 16'd7, 16'd4));
         tick();
      end
      cfg_data = 16'd55;
      #1;
      check("hold_exit_ready", 64'(cfg_ready), 64'd1);
      tick();
      cfg_addr = 2'd1; cfg_data = 16'd5; cfg_last = 1'b1;
      #1;
      check("hold_commit_ready", 64'(cfg_ready), 64'd1);
      tick();
      cfg_valid = 1'b0; cfg_last = 1'b0;
      check("hold_w_N", w_N, pack4(16'd55, 16'd5, 16'd7, 16'd4));
      check("hold_epoch", 64'(cfg_epoch), 64'd3);
      wait_ready();

      // 256 single-beat commits from reset: epoch wraps to 0
      do_reset();
      for (int i = 0; i < 256; i++) begin
         wait_ready();
         cfg_valid = 1'b1; cfg_addr = 2'(i % 4); cfg_data = DW'(i); cfg_last = 1'b1;
         tick();
         cfg_valid = 1'b0; cfg_last = 1'b0;
         if (i == 254) check("wrap_epoch_255", 64'(cfg_epoch), 64'd255);
      end
      check("wrap_epoch_0", 64'(cfg_epoch), 64'd0);
      check("wrap_w_N", w_N, pack4(16'd252, 16'd253, 16'd254, 16'd255));
      check("wrap_err", 64'(cfg_err), 64'd0);
      wait_ready();

      // Reset asserted mid-burst: partial shadow lost, everything back to reset values
      in_valid = 1'b1;
      for (int b = 0; b < 2; b++) begin
         cfg_valid = 1'b1; cfg_addr = 2'(b); cfg_data = DW'(11 + b); cfg_last = 1'b0;
         tick();
      end
      cfg_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_ready", 64'(cfg_ready), 64'd1);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_w_N", w_N, 64'd0);
      check("midrst_epoch", 64'(cfg_epoch), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      cfg_valid = 1'b1; cfg_addr = 2'd3; cfg_data = 16'd1; cfg_last = 1'b1;
      tick();
      cfg_valid = 1'b0; cfg_last = 1'b0;
      check("midrst_commit_w_N", w_N, pack4(16'd0, 16'd0, 16'd0, 16'd1));
      check("midrst_commit_epoch", 64'(cfg_epoch), 64'd1);
      check("midrst_commit_ready", 64'(cfg_ready), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/fir_coef_ctrl.md
Name: fir_coef_ctrl

Overview:
- Controller that sits in front of the inverse-structure fir_filter instance.
- Owns the active coefficient bank driving the filter's w_N and accepts coefficient reprogramming over a valid/ready write channel into a shadow bank.
- Swaps the shadow bank into the active bank atomically on the last beat of a write burst.
- Qualifies filter output with a valid flag, suppressing output for the pipeline flush after every swap.

Parameters:
- TAPS, 4, number of filter taps; must match the fir_filter instance.
- DATA_WIDTH, 16, sample and coefficient width.
- LATENCY, 2*TAPS, filter latency from x_N to y_N in cycles; also the flush length.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  coefficient write beat valid
- cfg_ready  out  1  controller can accept a beat
- cfg_addr  in  $clog2(TAPS)  tap index
- cfg_data  in  DATA_WIDTH  coefficient value
- cfg_last  in  1  final beat of burst; triggers swap
- cfg_err  out  1  sticky: out-of-range address seen
- cfg_epoch  out  8  count of completed swaps
- in_valid  in  1  input sample valid
- in_data  in  DATA_WIDTH  input sample
- x_N  out  DATA_WIDTH  to filter x_N
- w_N  out  DATA_WIDTH x TAPS  to filter w_N (active bank)
- y_N  in  DATA_WIDTH  from filter y_N
- out_valid  out  1  y_N qualified
- out_data  out  DATA_WIDTH  equals y_N

Behaviour:
- Reset (async assert, sync release):
  - active and shadow banks all zero; FSM in IDLE.
  - cfg_ready=1, cfg_err=0, cfg_epoch=0, out_valid=0, flush counter=0, valid shift register all zero.
- FSM states:
  - IDLE: no pending writes; cfg_ready=1.
  - LOAD: shadow bank partially written; cfg_ready=1.
  - FLUSH: swap done, pipeline draining; cfg_ready=0.
- Transitions:
  - IDLE->LOAD on an accepted beat with cfg_last=0.
  - IDLE or LOAD -> FLUSH on an accepted beat with cfg_last=1.
  - LOAD stays in LOAD on further beats with cfg_last=0.
  - FLUSH->IDLE when the flush counter reaches 0.
- Beat acceptance:
  - A beat is accepted when cfg_valid & cfg_ready.
  - Shadow[cfg_addr] <= cfg_data.
  - If cfg_addr >= TAPS (non-power-of-2 TAPS only): beat is still accepted, no write occurs, cfg_err sets and stays set until reset.
- Swap:
  - On the accepted cfg_last beat, active <= shadow with the current beat merged in, at that same edge.
  - w_N reflects the new bank from the next cycle.
  - Untouched taps keep their shadow values; shadow is never cleared.
  - cfg_epoch increments at the swap edge, wrapping 255->0.
- Flush:
  - Counter loads LATENCY at the swap edge and decrements each cycle in FLUSH.
  - Leave FLUSH the cycle after the counter reads 1.
  - out_valid is forced 0 while in FLUSH.
- Datapath:
  - x_N = in_valid ? in_data : 0 (combinational zero-stuffing).
  - The filter runs continuously; in_valid is always accepted, including during FLUSH.
- Valid tracking:
  - LATENCY-deep shift register of in_valid.
  - out_valid = tail & (state != FLUSH).
  - in_valid high in cycle k produces out_valid in cycle k+LATENCY, unless masked by FLUSH.
- out_data = y_N passthrough. No arithmetic in this block; the width rules belong to the filter.
- Reset mid-burst or mid-flush: all state returns to reset values. A partial shadow update is lost.

Optional Feature:
- Macro: FIR_COEF_READBACK_EN.
- Defined: adds input rd_addr ($clog2(TAPS)) and output rd_data (DATA_WIDTH).
  - rd_data is registered active[rd_addr], one cycle latency.
  - rd_data resets to 0; out-of-range rd_addr returns 0.
- Undefined: those ports and registers are absent; the rest of the behaviour is unchanged.

Decomposition:
- Package fir_pkg holds:
  - state enum typedef fir_ctrl_state_t {IDLE, LOAD, FLUSH}
  - EPOCH_W=8
  - a function returning the default LATENCY from TAPS.
- Sub-module fir_valid_tracker: in_valid shift register plus flush down-counter. Inputs: start_flush, in_valid. Outputs: flushing, out_valid.

Test Plan:
- Reset then in_valid=1 with in_data=1 for 1 cycle, coefficients all zero -> out_valid=1 exactly 8 cycles later (TAPS=4), out_data=0, cfg_epoch=0.
- Burst addr 0..3 with data 1,2,3,4, last on addr 3 -> w_N={1,2,3,4} the cycle after the last beat; cfg_ready=0 and out_valid=0 for 8 cycles; cfg_epoch=1.
- Single beat addr 2, data 7, cfg_last=1 after the previous test -> active={1,2,7,4}; FLUSH for 8 cycles.
- cfg_valid held high during FLUSH -> no beat accepted; shadow unchanged; first acceptance on the cycle FLUSH exits.
- 256 single-beat commits -> cfg_epoch wraps to 0. Assert rst_n low mid-burst (2 of 4 beats) -> banks zero, state IDLE, cfg_ready=1, out_valid=0.
- With FIR_COEF_READBACK_EN defined: rd_addr=1 after the second test -> rd_data=2 one cycle later.
